// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris game sequencer: playfield geometry,
// controller state encoding, piece indices and the piece-select LFSR step.
package tetris_pkg;

  localparam int ROWS        = 24;
  localparam int COLS        = 10;
  localparam int HIDDEN_ROWS = 4;

  typedef logic [4:0]                      row_t;
  typedef logic [3:0]                      col_t;
  typedef logic [COLS-1:0]                 row_bits_t;
  typedef logic [ROWS-1:0][COLS-1:0]       playfield_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPAWN    = 3'd1,
    ST_FALL     = 3'd2,
    ST_SCAN     = 3'd3,
    ST_SHIFT    = 3'd4,
    ST_GAMEOVER = 3'd5
  } ctrl_state_e;

  localparam int PIECE_O = 0;
  localparam int PIECE_I = 1;
  localparam int PIECE_T = 2;
  localparam int PIECE_S = 3;
  localparam int PIECE_Z = 4;
  localparam int PIECE_J = 5;
  localparam int PIECE_L = 6;

  localparam row_t      LAST_ROW      = 5'd23;
  localparam row_t      FIRST_VISIBLE = 5'd4;
  localparam row_bits_t FULL_ROW      = 10'h3FF;

  // Fibonacci step, taps 8,6,5,4, shifting towards the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/tetris_drop_timer.sv
// Gravity tick generator: synchronises frame_clk, detects its rising edges and
// emits a one-Clk Drop_Tick every Div edges while Run is high.
module tetris_drop_timer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        Run,
  input  logic [15:0] Div,
  output logic        Drop_Tick
);

  logic [1:0]  r_sync;
  logic        r_prev;
  logic [15:0] r_cnt;
  logic        r_tick;
  logic        w_edge;

  assign w_edge    = r_sync[1] & ~r_prev;
  assign Drop_Tick = r_tick;

  // Synchroniser, edge history and edge divider; count held at 0 while idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
      r_cnt  <= 16'd0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], frame_clk};
      r_prev <= r_sync[1];
      if (!Run) begin
        r_cnt  <= 16'd0;
        r_tick <= 1'b0;
      end else if (w_edge) begin
        if (r_cnt == Div - 16'd1) begin
          r_cnt  <= 16'd0;
          r_tick <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + 16'd1;
          r_tick <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tetris_game_ctrl.sv
// Tetris game sequencer: playfield, piece selection, landing merge, row collapse,
// gravity tick and game-over detection. Optional macro TETRIS_SPEEDUP_EN shortens
// the gravity divisor as lines are cleared.
module tetris_game_ctrl
  import tetris_pkg::*;
#(
  parameter int         NUM_PIECES = 7,
  parameter int         DROP_DIV   = 30,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             frame_clk,
  input  logic                             Start,
  input  logic [NUM_PIECES-1:0]            En_New_Static,
  input  logic [NUM_PIECES-1:0][3:0][4:0]  New_Static_Row,
  input  logic [NUM_PIECES-1:0][3:0][3:0]  New_Static_Column,
  output logic [NUM_PIECES-1:0]            Piece_Active,
  output logic                             Drop_Tick,
  output logic [23:0][9:0]                 Static_Array,
  output logic [15:0]                      Lines_Cleared,
  output logic                             Game_Over,
  output logic [2:0]                       Ctrl_State
);

  ctrl_state_e             r_state, w_state_nxt;
  logic [7:0]              r_lfsr;
  logic [2:0]              r_sel, w_sel;
  logic [NUM_PIECES-1:0]   r_active, w_onehot;
  playfield_t              r_array, w_cells, w_shifted;
  logic [15:0]             r_lines;
  logic                    r_top_hit;
  row_t                    r_ptr;
  logic                    w_land, w_cells_top, w_row_full, w_run;
  logic [15:0]             w_div;

  assign Piece_Active  = r_active;
  assign Static_Array  = r_array;
  assign Lines_Cleared = r_lines;

  // Piece choice from the LFSR; codes beyond the last piece fold onto piece 0.
  always_comb begin
    w_sel = 3'd0;
    if (int'(r_lfsr[2:0]) >= NUM_PIECES) begin
      w_sel = 3'd0;
    end else begin
      w_sel = r_lfsr[2:0];
    end
    w_onehot = {{(NUM_PIECES-1){1'b0}}, 1'b1} << w_sel;
  end

  // Landed cells of the active piece; off-field cells are discarded.
  always_comb begin
    w_land      = (r_state == ST_FALL) && En_New_Static[r_sel];
    w_cells     = '0;
    w_cells_top = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((New_Static_Row[r_sel][i] < 5'd24) && (New_Static_Column[r_sel][i] < 4'd10)) begin
        w_cells[New_Static_Row[r_sel][i]][New_Static_Column[r_sel][i]] = 1'b1;
      end else begin
        w_cells = w_cells;
      end
      w_cells_top = w_cells_top | (New_Static_Row[r_sel][i] < FIRST_VISIBLE);
    end
  end

  // Collapse: rows 1..ptr move down by one, row 0 refills empty.
  always_comb begin
    w_shifted    = r_array;
    w_shifted[0] = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (row_t'(r) <= r_ptr) begin
        w_shifted[r] = r_array[r-1];
      end else begin
        w_shifted[r] = r_array[r];
      end
    end
    w_row_full = (r_array[r_ptr] == FULL_ROW);
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     w_state_nxt = Start ? ST_SPAWN : ST_IDLE;
      ST_SPAWN:    w_state_nxt = ST_FALL;
      ST_FALL:     w_state_nxt = w_land ? ST_SCAN : ST_FALL;
      ST_SCAN: begin
        if (w_row_full) begin
          w_state_nxt = ST_SHIFT;
        end else if (r_ptr == FIRST_VISIBLE) begin
          w_state_nxt = r_top_hit ? ST_GAMEOVER : ST_SPAWN;
        end else begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SHIFT:    w_state_nxt = ST_SCAN;
      ST_GAMEOVER: w_state_nxt = Start ? ST_IDLE : ST_GAMEOVER;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    Ctrl_State = r_state;
    Game_Over  = (r_state == ST_GAMEOVER);
    w_run      = (r_state == ST_FALL);
  end

  // Playfield, score, piece selection and scan pointer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lfsr    <= LFSR_SEED;
      r_sel     <= 3'd0;
      r_active  <= '0;
      r_array   <= '0;
      r_lines   <= 16'd0;
      r_top_hit <= 1'b0;
      r_ptr     <= LAST_ROW;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      case (r_state)
        ST_IDLE: begin
          r_array  <= '0;
          r_active <= '0;
          if (Start) begin
            r_lines   <= 16'd0;
            r_top_hit <= 1'b0;
          end
        end
        ST_SPAWN: begin
          r_sel    <= w_sel;
          r_active <= w_onehot;
        end
        ST_FALL: begin
          if (w_land) begin
            r_array  <= r_array | w_cells;
            r_active <= '0;
            r_ptr    <= LAST_ROW;
            if (w_cells_top) begin
              r_top_hit <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (!w_row_full && (r_ptr != FIRST_VISIBLE)) begin
            r_ptr <= r_ptr - 5'd1;
          end
        end
        ST_SHIFT: begin
          r_array <= w_shifted;
          if (r_lines != 16'hFFFF) begin
            r_lines <= r_lines + 16'd1;
          end
        end
        ST_GAMEOVER: r_active <= '0;
        default: begin
          r_active <= '0;
        end
      endcase
    end
  end

`ifdef TETRIS_SPEEDUP_EN
  logic [15:0] r_div;
  logic [31:0] w_dec, w_div_calc;

  // Faster gravity every ten lines, latched only when a new piece spawns.
  always_comb begin
    w_dec = 32'(r_lines / 16'd10) * 32'd3;
    if (32'(DROP_DIV) > (w_dec + 32'd6)) begin
      w_div_calc = 32'(DROP_DIV) - w_dec;
    end else begin
      w_div_calc = 32'd6;
    end
  end

  // Divisor register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div <= 16'(DROP_DIV);
    end else if (r_state == ST_SPAWN) begin
      r_div <= w_div_calc[15:0];
    end
  end

  assign w_div = r_div;
`else
  assign w_div = 16'(DROP_DIV);
`endif

  tetris_drop_timer u_drop_timer (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .Run       (w_run),
    .Div       (w_div),
    .Drop_Tick (Drop_Tick)
  );

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Directed self-checking bench for tetris_game_ctrl (default build, DROP_DIV=30).
module tb_tetris_game_ctrl;

  logic                 Clk = 1'b0;
  logic                 Reset, frame_clk, Start;
  logic [6:0]           En_New_Static;
  logic [6:0][3:0][4:0] New_Static_Row;
  logic [6:0][3:0][3:0] New_Static_Column;
  logic [6:0]           Piece_Active;
  logic                 Drop_Tick;
  logic [23:0][9:0]     Static_Array;
  logic [15:0]          Lines_Cleared;
  logic                 Game_Over;
  logic [2:0]           Ctrl_State;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  tetris_game_ctrl dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .frame_clk         (frame_clk),
    .Start             (Start),
    .En_New_Static     (En_New_Static),
    .New_Static_Row    (New_Static_Row),
    .New_Static_Column (New_Static_Column),
    .Piece_Active      (Piece_Active),
    .Drop_Tick         (Drop_Tick),
    .Static_Array      (Static_Array),
    .Lines_Cleared     (Lines_Cleared),
    .Game_Over         (Game_Over),
    .Ctrl_State        (Ctrl_State)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // LFSR after reset: s0=A5, s1=4A, s2=95 (sel 5), ... s7=A7 (code 7 -> sel 0).
  // Start is sampled at edge k, so SPAWN sees s_k.
  task automatic reset_start(input int k);
    Reset = 1'b1; Start = 1'b0; En_New_Static = '0; frame_clk = 1'b0;
    step();
    Reset = 1'b0;
    repeat (k - 1) step();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] a, input logic [2:0] b, input int limit, input string name);
    int n;
    n = 0;
    while (Ctrl_State !== a && Ctrl_State !== b && n < limit) begin
      step();
      n++;
    end
    total++;
    if (Ctrl_State !== a && Ctrl_State !== b) begin
      bad++;
      $display("FAIL %s timeout: state=%0d wanted %0d or %0d", name, Ctrl_State, a, b);
    end
  endtask

  // Same cells offered by every piece, so the landing works whatever sel is.
  task automatic land(input logic [3:0][4:0] rows, input logic [3:0][3:0] cols, input bit wait_done);
    wait_state(3'd2, 3'd2, 20, "land_fall");
    for (int p = 0; p < 7; p++) begin
      New_Static_Row[p]    = rows;
      New_Static_Column[p] = cols;
    end
    En_New_Static = '1;
    step();
    En_New_Static = '0;
    if (wait_done) wait_state(3'd1, 3'd5, 60, "land_done");
  endtask

  task automatic frame_edge(output int ticks);
    ticks = 0;
    frame_clk = 1'b1;
    repeat (3) begin step(); if (Drop_Tick === 1'b1) ticks++; end
    frame_clk = 1'b0;
    repeat (3) begin step(); if (Drop_Tick === 1'b1) ticks++; end
  endtask

  task automatic test_reset();
    int t0, t1;
    Reset = 1'b1; Start = 1'b0; En_New_Static = '0; frame_clk = 1'b0;
    New_Static_Row = '0; New_Static_Column = '0;
    step(); step();
    total++; if (Ctrl_State !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", Ctrl_State); end
    total++; if (Static_Array !== '0) begin bad++; $display("FAIL reset_array got=%h exp=0", Static_Array); end
    total++; if (Piece_Active !== 7'd0) begin bad++; $display("FAIL reset_active got=%b exp=0", Piece_Active); end
    total++; if (Lines_Cleared !== 16'd0) begin bad++; $display("FAIL reset_lines got=%0d exp=0", Lines_Cleared); end
    total++; if (Game_Over !== 1'b0 || Drop_Tick !== 1'b0) begin bad++; $display("FAIL reset_flags go=%b tick=%b exp=0", Game_Over, Drop_Tick); end
    Reset = 1'b0;
    frame_edge(t0);
    frame_edge(t1);
    total++; if (t0 + t1 != 0) begin bad++; $display("FAIL idle_no_tick got=%0d exp=0", t0 + t1); end
  endtask

  task automatic test_spawn_drop();
    int t, first, n;
    reset_start(2);
    total++; if (Ctrl_State !== 3'd1) begin bad++; $display("FAIL spawn_state got=%0d exp=1", Ctrl_State); end
    total++; if (Piece_Active !== 7'd0) begin bad++; $display("FAIL spawn_active got=%b exp=0", Piece_Active); end
    step();
    total++; if (Ctrl_State !== 3'd2) begin bad++; $display("FAIL fall_state got=%0d exp=2", Ctrl_State); end
    total++; if (Piece_Active !== 7'b0100000) begin bad++; $display("FAIL fall_active got=%b exp=0100000", Piece_Active); end
    first = 0; n = 0;
    for (int e = 1; e <= 60; e++) begin
      frame_edge(t);
      if (t > 0) begin
        n += t;
        if (first == 0) first = e;
      end
    end
    total++; if (first != 30) begin bad++; $display("FAIL drop_first_edge got=%0d exp=30", first); end
    total++; if (n != 2) begin bad++; $display("FAIL drop_count got=%0d exp=2", n); end
  endtask

  task automatic test_touchdown();
    int n;
    reset_start(7);
    step();
    total++; if (Piece_Active !== 7'b0000001) begin bad++; $display("FAIL td_active got=%b exp=0000001", Piece_Active); end
    New_Static_Row    = '0;
    New_Static_Column = '0;
    New_Static_Row[0]    = {5'd23, 5'd23, 5'd22, 5'd22};
    New_Static_Column[0] = {4'd4, 4'd5, 4'd4, 4'd5};
    En_New_Static = 7'b0000001;
    step();
    En_New_Static = '0;
    total++; if (Static_Array[23] !== 10'h030 || Static_Array[22] !== 10'h030) begin bad++; $display("FAIL td_rows got=%h/%h exp=030/030", Static_Array[23], Static_Array[22]); end
    total++; if (Static_Array[21] !== 10'h000) begin bad++; $display("FAIL td_row21 got=%h exp=000", Static_Array[21]); end
    total++; if (Piece_Active !== 7'd0) begin bad++; $display("FAIL td_active_off got=%b exp=0", Piece_Active); end
    total++; if (Ctrl_State !== 3'd3) begin bad++; $display("FAIL td_scan got=%0d exp=3", Ctrl_State); end
    n = 0;
    while (Ctrl_State !== 3'd1 && n < 40) begin step(); n++; end
    total++; if (n != 20) begin bad++; $display("FAIL td_scan_len got=%0d exp=20", n); end
    total++; if (Lines_Cleared !== 16'd0) begin bad++; $display("FAIL td_lines got=%0d exp=0", Lines_Cleared); end
  endtask

  task automatic test_back_to_back_clear();
    int n, shifts;
    reset_start(2);
    land({5'd23, 5'd23, 5'd23, 5'd23}, {4'd0, 4'd1, 4'd2, 4'd3}, 1'b1);
    total++; if (Static_Array[23] !== 10'h00F) begin bad++; $display("FAIL pre_row23a got=%h exp=00F", Static_Array[23]); end
    land({5'd23, 5'd23, 5'd23, 5'd23}, {4'd6, 4'd7, 4'd8, 4'd9}, 1'b1);
    land({5'd22, 5'd22, 5'd22, 5'd22}, {4'd0, 4'd1, 4'd2, 4'd3}, 1'b1);
    land({5'd22, 5'd22, 5'd22, 5'd22}, {4'd6, 4'd7, 4'd8, 4'd9}, 1'b1);
    total++; if (Static_Array[23] !== 10'h3CF || Static_Array[22] !== 10'h3CF) begin bad++; $display("FAIL pre_rows got=%h/%h exp=3CF/3CF", Static_Array[23], Static_Array[22]); end
    land({5'd23, 5'd23, 5'd22, 5'd22}, {4'd4, 4'd5, 4'd4, 4'd5}, 1'b0);
    n = 0; shifts = 0;
    while (Ctrl_State !== 3'd1 && n < 80) begin
      if (Ctrl_State === 3'd4) shifts++;
      step();
      n++;
    end
    total++; if (shifts != 2) begin bad++; $display("FAIL clr_shifts got=%0d exp=2", shifts); end
    total++; if (Lines_Cleared !== 16'd2) begin bad++; $display("FAIL clr_lines got=%0d exp=2", Lines_Cleared); end
    total++; if (Static_Array[23] !== 10'h000 || Static_Array[22] !== 10'h000) begin bad++; $display("FAIL clr_rows got=%h/%h exp=000/000", Static_Array[23], Static_Array[22]); end
    total++; if (Static_Array[0] !== 10'h000) begin bad++; $display("FAIL clr_row0 got=%h exp=000", Static_Array[0]); end
    total++; if (Ctrl_State !== 3'd1) begin bad++; $display("FAIL clr_respawn got=%0d exp=1", Ctrl_State); end
  endtask

  task automatic test_game_over();
    reset_start(2);
    land({5'd3, 5'd4, 5'd5, 5'd6}, {4'd0, 4'd0, 4'd0, 4'd0}, 1'b1);
    total++; if (Ctrl_State !== 3'd5) begin bad++; $display("FAIL go_state got=%0d exp=5", Ctrl_State); end
    total++; if (Game_Over !== 1'b1) begin bad++; $display("FAIL go_flag got=%b exp=1", Game_Over); end
    total++; if (Piece_Active !== 7'd0) begin bad++; $display("FAIL go_active got=%b exp=0", Piece_Active); end
    repeat (3) step();
    total++; if (Static_Array[3] !== 10'h001 || Static_Array[6] !== 10'h001) begin bad++; $display("FAIL go_frozen got=%h/%h exp=001/001", Static_Array[3], Static_Array[6]); end
    total++; if (Ctrl_State !== 3'd5) begin bad++; $display("FAIL go_hold got=%0d exp=5", Ctrl_State); end
    Start = 1'b1;
    step();
    Start = 1'b0;
    total++; if (Ctrl_State !== 3'd0) begin bad++; $display("FAIL go_idle got=%0d exp=0", Ctrl_State); end
    step();
    total++; if (Static_Array !== '0) begin bad++; $display("FAIL go_clear got=%h exp=0", Static_Array); end
    total++; if (Game_Over !== 1'b0) begin bad++; $display("FAIL go_flag_off got=%b exp=0", Game_Over); end
    Start = 1'b1;
    step();
    Start = 1'b0;
    total++; if (Ctrl_State !== 3'd1) begin bad++; $display("FAIL go_restart got=%0d exp=1", Ctrl_State); end
  endtask

  task automatic test_reset_in_shift();
    reset_start(2);
    land({5'd23, 5'd23, 5'd23, 5'd23}, {4'd0, 4'd1, 4'd2, 4'd3}, 1'b1);
    land({5'd23, 5'd23, 5'd23, 5'd23}, {4'd4, 4'd5, 4'd6, 4'd7}, 1'b1);
    land({5'd23, 5'd23, 5'd22, 5'd22}, {4'd8, 4'd9, 4'd0, 4'd1}, 1'b0);
    step();
    total++; if (Ctrl_State !== 3'd4) begin bad++; $display("FAIL rs_in_shift got=%0d exp=4", Ctrl_State); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    total++; if (Ctrl_State !== 3'd0) begin bad++; $display("FAIL rs_state got=%0d exp=0", Ctrl_State); end
    total++; if (Static_Array !== '0) begin bad++; $display("FAIL rs_array got=%h exp=0", Static_Array); end
    total++; if (Lines_Cleared !== 16'd0 || Piece_Active !== 7'd0) begin bad++; $display("FAIL rs_lines_active got=%0d/%b exp=0/0", Lines_Cleared, Piece_Active); end
  endtask

  task automatic test_ignore_other();
    reset_start(7);
    step();
    total++; if (Ctrl_State !== 3'd2) begin bad++; $display("FAIL ig_fall got=%0d exp=2", Ctrl_State); end
    New_Static_Row       = '0;
    New_Static_Column    = '0;
    New_Static_Row[0]    = {5'd23, 5'd23, 5'd23, 5'd23};
    New_Static_Column[0] = {4'd0, 4'd1, 4'd2, 4'd3};
    New_Static_Row[1]    = {5'd23, 5'd23, 5'd23, 5'd23};
    New_Static_Column[1] = {4'd4, 4'd5, 4'd6, 4'd7};
    En_New_Static = 7'b0000010;
    step();
    En_New_Static = '0;
    step();
    total++; if (Static_Array !== '0) begin bad++; $display("FAIL ig_array got=%h exp=0", Static_Array); end
    total++; if (Ctrl_State !== 3'd2) begin bad++; $display("FAIL ig_state got=%0d exp=2", Ctrl_State); end
    total++; if (Piece_Active !== 7'b0000001) begin bad++; $display("FAIL ig_active got=%b exp=0000001", Piece_Active); end
  endtask

  initial begin
    test_reset();
    test_spawn_drop();
    test_touchdown();
    test_back_to_back_clear();
    test_game_over();
    test_reset_in_shift();
    test_ignore_other();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
